// File: rtl/seq_ser_pkg.sv
// seq_ser_pkg: shared types and helpers for the serializer front end.
//   state_t : shifter FSM states
//   ptr_w() : FIFO pointer width, one extra bit beyond the index as wrap flag
package seq_ser_pkg;
    typedef enum logic {S_IDLE, S_SHIFT} state_t;
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/seq_ser_fifo.sv
// seq_ser_fifo: synchronous FIFO with wrap-flag pointers and a combinational head.
//   clk, rst_n : clock, async active-low reset
//   flush      : synchronous clear of both pointers (wins over push/pop)
//   push/wdata : write wdata when not full
//   pop        : advance head when not empty
//   rdata      : current head entry
//   full/empty : pointer-derived status
//   count      : number of stored entries
module seq_ser_fifo
    import seq_ser_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [ptr_w(DEPTH)-1:0]    count
);
    localparam int PW = ptr_w(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp, rp;
    logic             do_push, do_pop;

    assign empty   = wp == rp;
    assign full    = (wp ^ rp) == {1'b1, {(PW-1){1'b0}}};
    assign count   = wp - rp;
    assign rdata   = mem[rp[PW-2:0]];
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else if (flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + PW'(1);
            if (do_pop) rp <= rp + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp[PW-2:0]] <= wdata;
    end
endmodule

// File: rtl/seq_serializer.sv
// seq_serializer: buffers WIDTH-bit words and streams them MSB first with no gaps.
//   clk, rst_n          : clock, async active-low reset
//   flush               : synchronous abort of current word and FIFO contents
//   din_data/valid/ready: input word handshake (din_ready registered)
//   dout, dout_valid    : serial bit and its qualifier
//   word_done           : high on the LSB of each word
//   busy                : shifting or words queued
module seq_serializer
    import seq_ser_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] din_data,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             word_done,
    output logic             busy
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = $clog2(WIDTH);
    state_t           state, state_n;
    logic [WIDTH-1:0] shreg, shreg_n, rdata;
    logic [CW-1:0]    bit_cnt, cnt_n;
    logic [PW-1:0]    count, count_n;
    logic             push, pop, full, empty, done_n, rdy_n;

    assign push       = din_valid && din_ready && !full;
    assign dout       = shreg[WIDTH-1];
    assign dout_valid = state == S_SHIFT;
    assign busy       = dout_valid || !empty;

    seq_ser_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (din_data),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // The shift register drains to zero by the end of each word, so dout is
    // already 0 whenever the FSM idles.
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        cnt_n   = bit_cnt;
        pop     = 1'b0;
        if (state == S_SHIFT) begin
            shreg_n = shreg << 1;
            cnt_n   = bit_cnt - CW'(1);
            if (bit_cnt == '0) state_n = S_IDLE;
        end
        if ((state == S_IDLE || bit_cnt == '0) && !empty) begin
            pop     = 1'b1;
            shreg_n = rdata;
            cnt_n   = CW'(WIDTH - 1);
            state_n = S_SHIFT;
        end
        if (flush) begin
            pop     = 1'b0;
            shreg_n = '0;
            cnt_n   = '0;
            state_n = S_IDLE;
        end
        count_n = flush ? '0 : count + PW'(push) - PW'(pop);
        rdy_n   = (count_n < PW'(DEPTH)) && !flush;
        done_n  = state_n == S_SHIFT && cnt_n == '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
            din_ready <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            bit_cnt   <= cnt_n;
            word_done <= done_n;
            din_ready <= rdy_n;
        end
    end
endmodule

// File: tb/tb_seq_serializer.sv
// tb_seq_serializer: randomized and directed checks of seq_serializer against a bitstream model.
module tb_seq_serializer;
    localparam int W = 8;
    localparam int D = 4;
    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, din_valid = 1'b0;
    logic [W-1:0] din_data = '0;
    logic din_ready, dout, dout_valid, word_done, busy;
    int tests = 0, fails = 0;
    bit exp[$];
    bit got[$];
    bit dn[$];
    int acc_cnt = 0, acc_old = 0, gaps = 0;
    bit acc_flag = 1'b0;

    seq_serializer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .din_data   (din_data),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .word_done  (word_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Model: every accepted word contributes W bits MSB first; once a word has been
    // accepted at least one edge before the current cycle, the stream must not stall.
    always @(negedge clk) begin
        if (dout_valid) begin
            got.push_back(dout);
            dn.push_back(word_done);
        end else if (got.size() < W * acc_old) gaps++;
        acc_old = acc_cnt;
        acc_flag = din_valid && din_ready && rst_n && !flush;
        if (acc_flag) begin
            acc_cnt++;
            for (int i = W - 1; i >= 0; i--) exp.push_back(din_data[i]);
        end
    end

    function automatic void mon_clear();
        got.delete();
        dn.delete();
        exp.delete();
        acc_cnt = 0;
        acc_old = 0;
        gaps = 0;
    endfunction

    function automatic logic [63:0] pack(input int s, input int n, input bit use_dn);
        logic [63:0] v = '0;
        for (int i = s; i < s + n; i++) v = {v[62:0], use_dn ? dn[i] : got[i]};
        return v;
    endfunction

    task automatic wait_bits(input int n);
        for (int i = 0; i < 400 && got.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        if (got.size() < n) begin
            $display("FAIL wait_bits: got %0d bits, need %0d", got.size(), n);
            $fatal(1, "timeout");
        end
    endtask

    task automatic wait_idle();
        int i = 0;
        do begin
            @(posedge clk);
            #1;
            i++;
        end while ((busy || dout_valid) && i < 400);
        if (busy) begin
            $display("FAIL wait_idle: busy still %b", busy);
            $fatal(1, "timeout");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({din_ready, dout, dout_valid, word_done, busy} !== 5'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected 00000", {din_ready, dout, dout_valid, word_done, busy});
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (din_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: din_ready=%b busy=%b expected 1 0", din_ready, busy);
        end
        mon_clear();
    endtask

    task automatic test_single();
        logic [7:0] hits = '0;
        logic [3:0] win = '0;
        wait_idle();
        mon_clear();
        din_data = 8'hD6;
        din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if (dout_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_latency_early: dout_valid=%b expected 0", dout_valid);
        end
        @(negedge clk);
        #1;
        tests++;
        if (dout_valid !== 1'b1 || dout !== 1'b1) begin
            fails++;
            $display("FAIL single_first_bit: dout_valid=%b dout=%b expected 1 1", dout_valid, dout);
        end
        wait_bits(W);
        repeat (3) @(negedge clk);
        tests++;
        if (got.size() != W || pack(0, W, 0) !== 64'hD6) begin
            fails++;
            $display("FAIL single_bits: got %0d bits value %h expected 8 bits d6", got.size(), pack(0, W, 0));
        end
        tests++;
        if (pack(0, W, 1) !== 64'h01) begin
            fails++;
            $display("FAIL single_word_done: got %b expected 00000001", pack(0, W, 1)[7:0]);
        end
        for (int i = 0; i < W; i++) begin
            win = {win[2:0], got[i]};
            if (i >= 3 && (win == 4'b1101 || win == 4'b0110)) hits[i] = 1'b1;
        end
        tests++;
        if (hits !== 8'h88) begin
            fails++;
            $display("FAIL single_detector: hit mask %b expected 10001000", hits);
        end
    endtask

    task automatic test_back_to_back();
        wait_idle();
        mon_clear();
        din_data = 8'hA5;
        din_valid = 1'b1;
        @(posedge clk);
        #1 din_data = 8'h3C;
        @(posedge clk);
        #1 din_valid = 1'b0;
        wait_bits(2 * W);
        tests++;
        if (pack(0, 2 * W, 0) !== 64'hA53C || gaps != 0) begin
            fails++;
            $display("FAIL b2b_bits: got %h gaps %0d expected a53c gaps 0", pack(0, 2 * W, 0), gaps);
        end
        tests++;
        if (pack(0, 2 * W, 1) !== 64'h0101) begin
            fails++;
            $display("FAIL b2b_word_done: got %h expected 0101", pack(0, 2 * W, 1));
        end
    endtask

    task automatic test_full();
        logic [W-1:0] w [6];
        logic [63:0] ref_bits = '0;
        int idx = 0, first_low = -1;
        logic rdy_last = 1'bx, rdy_pop2 = 1'bx;
        wait_idle();
        mon_clear();
        for (int i = 0; i < 6; i++) begin
            w[i] = {4'(i + 1), 4'($urandom)};
            ref_bits = {ref_bits[55:0], w[i]};
        end
        din_data = w[0];
        din_valid = 1'b1;
        for (int c = 0; c < 300 && !(idx == 6 && got.size() >= 6 * W); c++) begin
            @(negedge clk);
            #1;
            if (!din_ready && first_low < 0) first_low = acc_cnt;
            if (got.size() == W) rdy_last = din_ready;
            if (got.size() == W + 1) rdy_pop2 = din_ready;
            @(posedge clk);
            #1;
            if (acc_flag && idx < 6) begin
                idx++;
                if (idx == 6) din_valid = 1'b0;
                else din_data = w[idx];
            end
        end
        din_valid = 1'b0;
        tests++;
        if (first_low != 5) begin
            fails++;
            $display("FAIL full_accept_count: accepted %0d before ready low, expected 5", first_low);
        end
        tests++;
        if (rdy_last !== 1'b0 || rdy_pop2 !== 1'b1) begin
            fails++;
            $display("FAIL full_ready_return: before pop %b after pop %b expected 0 1", rdy_last, rdy_pop2);
        end
        tests++;
        if (idx != 6 || got.size() < 6 * W || pack(0, 6 * W, 0) !== ref_bits || gaps != 0) begin
            fails++;
            $display("FAIL full_stream: words %0d bits %h gaps %0d expected 6 %h 0", idx,
                     pack(0, 6 * W, 0), gaps, ref_bits);
        end
    endtask

    task automatic test_flush();
        wait_idle();
        mon_clear();
        din_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din_data = W'($urandom);
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        wait_bits(3);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        mon_clear();
        @(negedge clk);
        #1;
        tests++;
        if ({dout, dout_valid, word_done, busy, din_ready} !== 5'b0) begin
            fails++;
            $display("FAIL flush_outputs: dout/valid/done/busy/ready %b expected 00000",
                     {dout, dout_valid, word_done, busy, din_ready});
        end
        @(negedge clk);
        #1;
        tests++;
        if (din_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_ready_return: din_ready %b expected 1", din_ready);
        end
        repeat (20) @(negedge clk);
        #1;
        tests++;
        if (got.size() != 0) begin
            fails++;
            $display("FAIL flush_discard: %0d bits emitted after flush, expected 0", got.size());
        end
        @(posedge clk);
        #1;
        mon_clear();
        din_data = 8'hFF;
        din_valid = 1'b1;
        @(posedge clk);
        #1 din_valid = 1'b0;
        wait_bits(W);
        repeat (3) @(negedge clk);
        tests++;
        if (got.size() != W || pack(0, W, 0) !== 64'hFF || pack(0, W, 1) !== 64'h01) begin
            fails++;
            $display("FAIL flush_restart: %0d bits value %h done %h expected 8 ff 01", got.size(),
                     pack(0, W, 0), pack(0, W, 1));
        end
    endtask

    task automatic test_async_reset();
        wait_idle();
        mon_clear();
        din_data = 8'hFF;
        din_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 din_valid = 1'b0;
        wait_bits(3);
        tests++;
        if (dout_valid !== 1'b1 || dout !== 1'b1) begin
            fails++;
            $display("FAIL areset_pre: dout_valid=%b dout=%b expected 1 1", dout_valid, dout);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({din_ready, dout, dout_valid, word_done, busy} !== 5'b0) begin
            fails++;
            $display("FAIL areset_immediate: got %b expected 00000", {din_ready, dout, dout_valid, word_done, busy});
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_clear();
        tests++;
        if (din_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL areset_release: din_ready=%b busy=%b expected 1 0", din_ready, busy);
        end
        repeat (15) @(negedge clk);
        #1;
        tests++;
        if (got.size() != 0) begin
            fails++;
            $display("FAIL areset_empty: %0d bits emitted after reset, expected 0", got.size());
        end
    endtask

    task automatic test_random();
        int bad_bits = 0, bad_done = 0, c = 0;
        wait_idle();
        mon_clear();
        for (int i = 0; i < 2000; i++) begin
            din_valid = ((i / 250) % 2) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
            din_data = W'($urandom);
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        while ((busy || got.size() < exp.size()) && c < 400) begin
            @(negedge clk);
            #1;
            c++;
        end
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            if (got[i] !== exp[i]) bad_bits++;
            if (dn[i] !== (i % W == W - 1)) bad_done++;
        end
        tests++;
        if (got.size() != exp.size() || bad_bits != 0 || exp.size() == 0) begin
            fails++;
            $display("FAIL random_stream: %0d bits, %0d wrong, expected %0d bits 0 wrong", got.size(),
                     bad_bits, exp.size());
        end
        tests++;
        if (bad_done != 0) begin
            fails++;
            $display("FAIL random_word_done: %0d misplaced, expected 0", bad_done);
        end
        tests++;
        if (gaps != 0) begin
            fails++;
            $display("FAIL random_gaps: %0d stalled cycles, expected 0", gaps);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_flush();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seq_serializer.md
# seq_serializer

Parallel-to-serial front end for the serial pattern detector. It accepts WIDTH-bit words over a valid/ready handshake and buffers them in a small FIFO. It streams each word out one bit per clock, MSB first, on `dout`, which drives the detector's `din`. Back-to-back words are emitted with no idle bit between them, so the detector sees a continuous bitstream.

## Interface
- `WIDTH`, 8: bits per input word, ≥2.
- `DEPTH`, 4: FIFO entries, power of two, ≥2.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous clear; empties the FIFO and aborts the current word.
- `din_data` in WIDTH: word to serialize.
- `din_valid` in 1: `din_data` is valid.
- `din_ready` out 1: FIFO can accept; a transfer occurs when `din_valid && din_ready` at a rising edge.
- `dout` out 1: serial bit, MSB of the word first.
- `dout_valid` out 1: `dout` carries a data bit this cycle.
- `word_done` out 1: high during the last bit (LSB) of each word.
- `busy` out 1: shifter active or FIFO non-empty.

## Operation
- Reset values: `din_ready`=0, `dout`=0, `dout_valid`=0, `word_done`=0, `busy`=0; FIFO count 0; state S_IDLE.
- FIFO:
  - Read/write pointers are log2(DEPTH)+1 bits, with the extra bit used as the wrap flag.
  - full = (pointers differ only in the MSB); empty = (pointers equal).
  - Push and pop in the same cycle leave the count unchanged.
- `din_ready` is registered: next value = (count_next < DEPTH) && !flush.
- Pushes are accepted only when `din_ready` is high. A push into an empty FIFO is not bypassed to the shifter in the same cycle.
- Shifter FSM:
  - S_IDLE:
    - FIFO empty: stay in S_IDLE; `dout`=0, `dout_valid`=0.
    - FIFO non-empty: pop the head into the shift register, load `bit_cnt`=WIDTH-1, go to S_SHIFT.
  - S_SHIFT:
    - `dout` = shreg[WIDTH-1] and `dout_valid`=1.
    - Each edge shifts the register left by one (zero fill) and decrements `bit_cnt`.
    - When `bit_cnt`==0, `word_done`=1.
    - At that edge, if the FIFO is non-empty, pop and reload immediately (stay in S_SHIFT, no gap).
    - Otherwise, go to S_IDLE.
- `flush` (priority over push and pop):
  - At the edge: both pointers are cleared and the FSM goes to S_IDLE.
  - The partial word is discarded.
  - From the next cycle, `dout`/`dout_valid`/`word_done` are 0 and `din_ready`=0.
  - `din_ready` returns to 1 one cycle after `flush` deasserts.
- Asynchronous reset mid-word forces all reset values immediately; the buffered words are lost.
- `busy` = (state==S_SHIFT) || !empty.

## Timing
- Outputs `dout`, `dout_valid`, `word_done`, `din_ready` are registered; `busy` may be combinational from registers.
- First-bit latency: a word accepted at edge N into an empty, idle block is popped at edge N+1. `dout_valid` rises after edge N+1, and the MSB is valid for the cycle N+1→N+2.
- One word occupies exactly WIDTH cycles of `dout_valid`. Sustained throughput is one word per WIDTH cycles with no bubbles while the FIFO is non-empty.
- Full FIFO: `din_ready` is low from the edge after the entry that fills it. It rises one edge after the next pop.
- Bit order is fixed MSB first.

## Structure
- Package `seq_ser_pkg`:
  - `state_t` enum (S_IDLE, S_SHIFT).
  - Localparam helper for the pointer width, $clog2(DEPTH)+1.
- Sub-module `seq_ser_fifo`:
  - Parameterised WIDTH/DEPTH synchronous FIFO.
  - Ports: push, pop, wdata, rdata (head, combinational), full, empty, flush.
- Top level: handshake register, shifter, bit counter, FSM.

## Test plan
- Reset, then push 8'hD6 once: `dout` = 1,1,0,1,0,1,1,0 on 8 consecutive cycles, starting the cycle after the pop edge. `word_done` is high only on the final 0. A downstream detector fed by `dout` flags after the 4th bit (1101) and after the 8th bit (0110).
- Push 8'hA5 then 8'h3C on consecutive cycles: 16 consecutive `dout_valid` cycles with `dout` = 10100101_00111100, and `word_done` high on cycles 8 and 16.
- Hold `din_valid` high with 6 distinct words (DEPTH=4):
  - 5 accepted; `din_ready` low after the 5th.
  - `din_ready` rises one edge after word 2 is popped.
  - All 6 words emerge in order with no gap.
- Assert `flush` for 1 cycle at bit 3 of word 1 with 2 words queued: `dout_valid`=0 the next cycle, `busy`=0, and no queued bits are emitted later. The next pushed word 8'hFF streams normally.
- Drop `rst_n` asynchronously mid-word: outputs are 0 immediately without waiting for a clock edge. After release, `din_ready` rises on the first edge and the FIFO is empty.
- Random push pattern over 2000 cycles: a scoreboard checks the concatenated bitstream equals the accepted words MSB-first. `dout_valid` never drops while the FIFO is non-empty.
